// File: rtl/fetch_unit_if.sv
// Bundles fetch-stage signals: redirect input, instruction-memory port and decode handshake.
// No latency of its own; it only groups wires.
// Backpressure runs over the decode valid/ready pair (valid_o/ready_i).
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  redirect_valid_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [31:0]           imem_rdata_i;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  valid_o;
    logic                  ready_i;

    // Fetch-unit side
    modport master (
        input  redirect_valid_i, redirect_pc_i, imem_rdata_i, ready_i,
        output imem_req_o, imem_addr_o, instr_o, pc_o, valid_o
    );

    // Environment side: decode, memory and redirect source
    modport slave (
        output redirect_valid_i, redirect_pc_i, imem_rdata_i, ready_i,
        input  imem_req_o, imem_addr_o, instr_o, pc_o, valid_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, queues {instr, pc} for decode.
// Latency: request issued in cycle N, data queued at end of N+1, valid_o in N+2 (redirect: target valid in N+3).
// Backpressure: issue only while queued + in-flight < QUEUE_DEPTH; head holds steady while ready_i is low.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_pc_q;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic                  r_inflight;

    logic [CNT_W:0]        w_occupancy;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;

    // Occupancy counts the outstanding request so a returning word always has a slot.
    // A pop in the same cycle is deliberately not credited, keeping the issue path short.
    assign w_occupancy = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
    assign w_issue     = !rst && !bus.redirect_valid_i
                         && (w_occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    // A redirect never coexists with a live in-flight response: no issue happens in the
    // redirect cycle, so the flush below is all the squashing needed.
    assign w_push      = r_inflight;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && bus.ready_i;

    assign bus.imem_req_o  = w_issue;
    assign bus.imem_addr_o = r_pc_q;
    assign bus.valid_o     = w_valid;
    assign bus.instr_o     = w_valid ? r_mem[r_head].instr : '0;
    assign bus.pc_o        = w_valid ? r_mem[r_head].pc    : '0;

    // PC, in-flight tracking and queue pointers; reset beats redirect beats normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q        <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else if (bus.redirect_valid_i) begin
            r_pc_q     <= {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            assert (!(w_push && !w_pop && r_count == CNT_W'(QUEUE_DEPTH)));
            if (w_issue) begin
                r_pc_q        <= r_pc_q + ADDR_WIDTH'(4);
                r_inflight_pc <= r_pc_q;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Queue storage: capture the returning word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect_valid_i && w_push) begin
            r_mem[r_tail] <= '{instr: bus.imem_rdata_i, pc: r_inflight_pc};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int          AW  = 32;
    localparam logic [31:0] RPC = 32'h100;
    localparam int          QD  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   cyc = 0;
    int   start_cyc = -100;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic [31:0] next_pc;
    bit          pend_flush;
    logic [31:0] pend_pc;

    // monitor state
    int          d;
    int          stall_run = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_pc, prev_ins;
    exp_t        e;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.imem_req_o) bus.imem_rdata_i <= mem_fn(bus.imem_addr_o);
        else                bus.imem_rdata_i <= 32'hDEAD_BEEF;
    end

    // One cycle of stimulus; the reference stream is rebuilt after any reset/redirect.
    task automatic step(input bit r, input bit rd, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        if (pend_flush) begin
            exp_q.delete();
            next_pc    = pend_pc;
            pend_flush = 0;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_pc, ins: mem_fn(next_pc)});
            next_pc = next_pc + 32'd4;
        end
        #1;
        rst                  = r;
        bus.ready_i          = rd;
        bus.redirect_valid_i = rv;
        bus.redirect_pc_i    = rpc;
        if (r || rv) begin
            pend_flush = 1;
            pend_pc    = r ? RPC : {rpc[31:2], 2'b00};
            start_cyc  = cyc + 1;
        end
    endtask

    // Monitor: timing rules, stall stability and in-order delivery against the model stream.
    always @(negedge clk) begin
        if (rst) begin
            chk("req_in_reset", 32'(bus.imem_req_o), 32'd0);
            stall_run = 0;
            prev_hold = 0;
        end else begin
            d = cyc - start_cyc;
            if (bus.redirect_valid_i) chk("req_in_redirect", 32'(bus.imem_req_o), 32'd0);
            if (bus.imem_req_o) chk("addr_align", 32'(bus.imem_addr_o[1:0]), 32'd0);
            if (d == 0 || d == 1) chk("valid_before_fill", 32'(bus.valid_o), 32'd0);
            else if (d == 2)      chk("valid_after_fill", 32'(bus.valid_o), 32'd1);
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.valid_o), 32'd1);
                chk("hold_pc", bus.pc_o, prev_pc);
                chk("hold_instr", bus.instr_o, prev_ins);
            end
            if (!bus.redirect_valid_i && !bus.ready_i) stall_run++;
            else stall_run = 0;
            if (stall_run >= QD + 2) chk("req_when_full", 32'(bus.imem_req_o), 32'd0);
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got pc %h, no instruction expected", bus.pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", bus.pc_o, e.pc);
                    chk("instr", bus.instr_o, e.ins);
                end
            end
            prev_hold = bus.valid_o && !bus.ready_i && !bus.redirect_valid_i;
            prev_pc   = bus.pc_o;
            prev_ins  = bus.instr_o;
        end
    end

    initial begin
        bit          r, rd, rv;
        logic [31:0] rpc;
        rst                  = 1'b1;
        bus.ready_i          = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        pend_flush           = 1;
        pend_pc              = RPC;
        next_pc              = RPC;

        // reset then streaming
        repeat (3) step(1, 0, 0, 0);
        repeat (20) step(0, 1, 0, 0);
        // long stall, then release
        repeat (10) step(0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0);
        // unaligned redirect while a request is outstanding
        step(0, 1, 1, 32'h2003);
        repeat (12) step(0, 1, 0, 0);
        // back-to-back redirects, last wins
        step(0, 1, 1, 32'h400);
        step(0, 1, 1, 32'h800);
        repeat (12) step(0, 1, 0, 0);
        // PC wrap through the top of the address space
        step(0, 1, 1, 32'hFFFF_FFF4);
        repeat (14) step(0, 1, 0, 0);
        // reset with a full queue and an outstanding request
        repeat (6) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (12) step(0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 24) == 0);
            rd  = ($urandom_range(0, 3) != 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            step(r, rd, rv, rpc);
        end
        repeat (12) step(0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
